serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock with valid/ready ports.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic         ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int CW = $clog2(N + 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  d_sh;
    logic          bflop;
    logic          a0;
    logic          b0;
    logic          dbit;
    logic          bnext;
    logic          last;

    // Single full-subtractor cell shared across all bit positions
    assign a0    = a_sh[0];
    assign b0    = b_sh[0];
    assign dbit  = a0 ^ b0 ^ bflop;
    assign bnext = (~a0 & b0) | (~(a0 ^ b0) & bflop);
    assign last  = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            d_sh  <= '0;
            bflop <= 1'b0;
            cnt   <= '0;
        end else if (state == IDLE && in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            bflop <= 1'b0;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            d_sh  <= {dbit, d_sh[N-1:1]};
            bflop <= bnext;
            cnt   <= cnt + CW'(1);
        end
    end

    assign diff   = d_sh;
    assign borrow = bflop;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    // Operand MSBs are shifted out, so keep copies for the overflow test
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_msb <= a[N-1];
            b_msb <= b[N-1];
        end
    end

    assign ovf = (a_msb ^ b_msb) & (d_sh[N-1] ^ a_msb);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at N=4 and N=8.
// Honours SERIAL_SUB_SIGNED_OVF_EN for the overflow vectors.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;

    logic       iv4, ir4, ov4, or4, bw4;
    logic [3:0] a4, b4, d4;
    logic       iv8, ir8, ov8, or8, bw8;
    logic [7:0] a8, b8, d8;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic       ovf4, ovf8;
`endif

    int n_checks;
    int n_fail;

    serial_subtractor #(.N(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4),
        .diff(d4), .borrow(bw4)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        , .ovf(ovf4)
`endif
    );

    serial_subtractor #(.N(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8),
        .diff(d8), .borrow(bw8)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        , .ovf(ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: wait for in_ready, present operands for one accept edge,
    // then count edges until out_valid (-1 if it never comes).
    task automatic run_op4(input logic [3:0] x, input logic [3:0] y,
                           output int lat);
        int k;
        k = 0;
        while (!ir4 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        a4 = x; b4 = y; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ov4) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic hshake4();
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({ir4, ov4, bw4, d4} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset4: rdy/vld/bor/diff=%b %b %b %b want 1 0 0 0000",
                     ir4, ov4, bw4, d4);
        end
        n_checks++;
        if ({ir8, ov8, bw8, d8} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset8: rdy/vld/bor/diff=%b %b %b %h want 1 0 0 00",
                     ir8, ov8, bw8, d8);
        end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        n_checks++;
        if (ovf4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: ovf=%b want 0", ovf4);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        run_op4(4'd9, 4'd3, lat);
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 4", lat);
        end
        n_checks++;
        if ({ir4, bw4, d4} !== {1'b0, 1'b0, 4'b0110}) begin
            n_fail++;
            $display("FAIL basic_result: rdy/bor/diff=%b %b %b want 0 0 0110",
                     ir4, bw4, d4);
        end
        hshake4();
        n_checks++;
        if ({ir4, ov4} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_release: rdy/vld=%b%b want 10", ir4, ov4);
        end
    endtask

    task automatic test_boundary();
        logic [3:0] va [3] = '{4'd3, 4'd0, 4'd5};
        logic [3:0] vb [3] = '{4'd9, 4'd1, 4'd5};
        logic [3:0] vd [3] = '{4'b1010, 4'b1111, 4'b0000};
        logic       vw [3] = '{1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op4(va[i], vb[i], lat);
            n_checks++;
            if ({lat == 4, bw4, d4} !== {1'b1, vw[i], vd[i]}) begin
                n_fail++;
                $display("FAIL boundary%0d: lat=%0d bor=%b diff=%b want 4 %b %b",
                         i, lat, bw4, d4, vw[i], vd[i]);
            end
            hshake4();
        end
    endtask

    task automatic test_hold();
        int lat;
        run_op4(4'd7, 4'd2, lat);
        or4 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            iv4 = ~iv4;
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if ({ov4, ir4, bw4, d4} !== {1'b1, 1'b0, 1'b0, 4'd5}) begin
                n_fail++;
                $display("FAIL hold%0d: vld/rdy/bor/diff=%b %b %b %b want 1 0 0 0101",
                         i, ov4, ir4, bw4, d4);
            end
        end
        iv4 = 1'b0;
        hshake4();
        n_checks++;
        if ({ir4, ov4} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_release: rdy/vld=%b%b want 10", ir4, ov4);
        end
        run_op4(4'd14, 4'd6, lat);
        n_checks++;
        if ({lat == 4, bw4, d4} !== {1'b1, 1'b0, 4'b1000}) begin
            n_fail++;
            $display("FAIL hold_next: lat=%0d bor=%b diff=%b want 4 0 1000",
                     lat, bw4, d4);
        end
        hshake4();
    endtask

    task automatic test_reset_mid();
        int lat;
        a4 = 4'd15; b4 = 4'd1; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({ir4, ov4, bw4, d4} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: rdy/vld/bor/diff=%b %b %b %b want 1 0 0 0000",
                     ir4, ov4, bw4, d4);
        end
        run_op4(4'd12, 4'd4, lat);
        n_checks++;
        if ({lat == 4, bw4, d4} !== {1'b1, 1'b0, 4'b1000}) begin
            n_fail++;
            $display("FAIL reset_mid_next: lat=%0d bor=%b diff=%b want 4 0 1000",
                     lat, bw4, d4);
        end
        hshake4();
    endtask

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    task automatic test_ovf();
        logic [3:0] va [3] = '{4'b1000, 4'b0111, 4'b0101};
        logic [3:0] vb [3] = '{4'b0001, 4'b1111, 4'b0011};
        logic [3:0] vd [3] = '{4'b0111, 4'b1000, 4'b0010};
        logic       vo [3] = '{1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op4(va[i], vb[i], lat);
            n_checks++;
            if ({lat == 4, ovf4, d4} !== {1'b1, vo[i], vd[i]}) begin
                n_fail++;
                $display("FAIL ovf%0d: lat=%0d ovf=%b diff=%b want 4 %b %b",
                         i, lat, ovf4, d4, vo[i], vd[i]);
            end
            hshake4();
        end
    endtask
`endif

    task automatic test_random8();
        logic [7:0] x, y;
        logic [8:0] exp;
        int k, lat;
        for (int n = 0; n < 200; n++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            if (n == 0) begin x = 8'd0; y = 8'd255; end
            if (n == 1) begin x = 8'd255; y = 8'd0; end
            exp = {1'b0, x} - {1'b0, y};
            k = 0;
            while (!ir8 && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            a8 = x; b8 = y; iv8 = 1'b1;
            @(posedge clk); #1;
            iv8 = 1'b0;
            lat = -1;
            for (int i = 1; i <= 16; i++) begin
                @(posedge clk); #1;
                if (ov8) begin
                    lat = i;
                    break;
                end
                or8 = 1'($urandom_range(0, 1));
            end
            or8 = 1'b0;
            for (int s = $urandom_range(0, 3); s > 0; s--) begin
                @(posedge clk); #1;
            end
            n_checks++;
            if ({lat == 8, ov8, bw8, d8} !== {1'b1, 1'b1, exp}) begin
                n_fail++;
                $display("FAIL rand%0d: %h-%h lat=%0d vld=%b bor=%b diff=%h want 8 1 %b %h",
                         n, x, y, lat, ov8, bw8, d8, exp[8], exp[7:0]);
            end
            or8 = 1'b1;
            @(posedge clk); #1;
            or8 = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
        #1;
        test_reset();
        test_basic();
        test_boundary();
        test_hold();
        test_reset_mid();
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        test_ovf();
`endif
        test_random8();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
